// File: rtl/conv_pkg.sv
// Shared widths, state encoding and word types for the convolution row adapter.
package conv_pkg;

    localparam int ROW_BYTES = 32;
    localparam int RES_COUNT = 30;
    localparam int PIX_W     = 8;
    localparam int RES_W     = 18;

    localparam int ROW_W   = ROW_BYTES * PIX_W;
    localparam int BYTE_CW = $clog2(ROW_BYTES);
    localparam int IDX_W   = $clog2(RES_COUNT);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_KICK  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } adapter_state_e;

    typedef logic signed [RES_W-1:0] res_word_t;

    typedef logic [RES_COUNT-1:0][RES_W-1:0] res_array_t;

endpackage

// File: rtl/conv_result_serializer.sv
// Captures the engine result array and streams it out one word per accepted beat.
// Optional ReLU on the output words is enabled by defining CONV_ADAPTER_RELU_EN.
module conv_result_serializer
    import conv_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                capture,
    input  logic [RES_COUNT-1:0][RES_W-1:0]     conv_result,
    input  logic                                out_ready,
    output logic signed [RES_W-1:0]             out_data,
    output logic                                out_valid,
    output logic                                out_last,
    output logic                                drain_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RES_COUNT - 1);

    // Valid/ready: a word transfers on a rising edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, out_data/out_last/out_valid hold.

    function automatic res_word_t shape_word(input res_word_t w);
`ifdef CONV_ADAPTER_RELU_EN
        return w[RES_W-1] ? res_word_t'(0) : w;
`else
        return w;
`endif
    endfunction

    logic [RES_COUNT-1:0][RES_W-1:0] res_buf_q, res_buf_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic signed [RES_W-1:0]         out_data_q, out_data_d;
    logic                            out_valid_q, out_valid_d;
    logic                            out_last_q, out_last_d;

    always_comb begin
        res_buf_d   = res_buf_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (capture) begin
            res_buf_d   = conv_result;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = shape_word(conv_result[0]);
            out_last_d  = 1'b0;
        end else if (out_valid_q && out_ready) begin
            if (out_last_q) begin
                idx_d       = '0;
                out_valid_d = 1'b0;
                out_data_d  = '0;
                out_last_d  = 1'b0;
            end else begin
                idx_d      = idx_q + 1'b1;
                out_data_d = shape_word(res_buf_q[idx_d]);
                out_last_d = (idx_d == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_buf_q   <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            res_buf_q   <= res_buf_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign drain_done = out_valid_q && out_ready && out_last_q;

endmodule

// File: rtl/conv_row_adapter.sv
// Packs 32 pixel bytes into a row, kicks the convolution engine and drains its 30 results.
// Output ReLU is selected at build time with CONV_ADAPTER_RELU_EN (see conv_result_serializer).
module conv_row_adapter
    import conv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [PIX_W-1:0]                    in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic                                conv_start,
    output logic [ROW_W-1:0]                    conv_row,
    input  logic                                conv_done,
    input  logic [RES_COUNT-1:0][RES_W-1:0]     conv_result,
    output logic signed [RES_W-1:0]             out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic                                timeout_err,
    output logic [1:0]                          dbg_state
);

    localparam int                 WAIT_CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [BYTE_CW-1:0] BYTE_LAST = BYTE_CW'(ROW_BYTES - 1);

    adapter_state_e     state_q, state_d;
    logic [BYTE_CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [WAIT_CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [ROW_W-1:0]   conv_row_q, conv_row_d;
    logic               in_ready_q, in_ready_d;
    logic               conv_start_q, conv_start_d;
    logic               timeout_err_q, timeout_err_d;

    logic accept;
    logic capture;
    logic drain_done;

    // in_ready_q is only ever high in FILL, so this also gates in_valid elsewhere.
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        conv_row_d    = conv_row_q;
        timeout_err_d = 1'b0;
        capture       = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    conv_row_d[int'(byte_cnt_q) * PIX_W +: PIX_W] = in_data;
                    if (byte_cnt_q == BYTE_LAST) begin
                        byte_cnt_d = '0;
                        state_d    = ST_KICK;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            ST_KICK: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the final allowed cycle still wins over the timeout.
                if (conv_done) begin
                    capture    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_DRAIN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    wait_cnt_d    = '0;
                    byte_cnt_d    = '0;
                    state_d       = ST_FILL;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    byte_cnt_d = '0;
                    state_d    = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        in_ready_d   = (state_d == ST_FILL);
        conv_start_d = (state_d == ST_KICK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            byte_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            conv_row_q    <= '0;
            in_ready_q    <= 1'b0;
            conv_start_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            conv_row_q    <= conv_row_d;
            in_ready_q    <= in_ready_d;
            conv_start_q  <= conv_start_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    conv_result_serializer u_serializer (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture     (capture),
        .conv_result (conv_result),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .drain_done  (drain_done)
    );

    assign in_ready    = in_ready_q;
    assign conv_start  = conv_start_q;
    assign conv_row    = conv_row_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/conv_row_adapter.md
CONV_ROW_ADAPTER -- requirements
Module: conv_row_adapter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: maximum number of WAIT cycles allowed for done_signal before the row is abandoned.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  8  signed pixel byte from the upstream stream.
REQ-005 in_valid  input  1  in_data is valid.
REQ-006 in_ready  output  1  adapter accepts in_data this cycle.
REQ-007 conv_start  output  1  single-cycle start pulse to the convolution engine.
REQ-008 conv_row  output  256  packed pixel row presented to the engine.
REQ-009 conv_done  input  1  engine completion pulse.
REQ-010 conv_result  input  18x30  signed engine result array, index 0..29.
REQ-011 out_data  output  18  signed result word to downstream.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 out_last  output  1  high with result index 29.
REQ-015 timeout_err  output  1  one-cycle pulse when a row is abandoned.

Function
REQ-016 The FSM SHALL have the states FILL, KICK, WAIT and DRAIN, and it SHALL enter FILL from reset.
- FILL: in_ready=1; on each in_valid&&in_ready, byte k SHALL be written to conv_row[8k+7:8k], with byte 0 as the first accepted; after the 32nd accept the FSM SHALL go to KICK.
- KICK: conv_start=1 for exactly one cycle; the FSM then goes to WAIT.
- WAIT: on conv_done=1, all 30 conv_result entries SHALL be captured into an internal buffer in that cycle, and the FSM goes to DRAIN.
- DRAIN: present buffer[i] for i=0..29 in order; i SHALL advance only on out_valid&&out_ready; after index 29 is accepted the FSM returns to FILL with the byte count at 0.
REQ-017 in_ready SHALL be 0 in KICK, WAIT and DRAIN, and in_valid SHALL be ignored in those states.
REQ-018 conv_row SHALL hold stable from KICK until conv_done is captured, and it SHALL change only in FILL.
REQ-019 conv_start SHALL assert the cycle after the 32nd byte is accepted.
REQ-020 out_valid SHALL assert the cycle after conv_done is sampled in WAIT.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold.
REQ-022 With out_ready held at 1, the 30 results SHALL be emitted in 30 consecutive cycles.
REQ-023 conv_done seen outside WAIT SHALL be ignored.
REQ-024 A WAIT cycle counter SHALL clear on entry to WAIT.
- If the counter reaches TIMEOUT_CYCLES without conv_done, timeout_err pulses for one cycle and the FSM goes to FILL, discarding the row.
- If conv_done and timeout occur in the same cycle, conv_done SHALL win.

Reset
REQ-025 When rst_n=0, the following SHALL clear asynchronously: state=FILL; byte count, result index and timeout counter=0; conv_row and buffer=0; in_ready=0 during reset; conv_start, out_valid, out_last and timeout_err=0; out_data=0.
REQ-026 Reset asserted mid-row or mid-drain SHALL abort the operation, and no partial output SHALL appear after release.
REQ-027 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-028 When CONV_ADAPTER_RELU_EN is defined, each negative buffered result SHALL be output as 0, and non-negative values SHALL pass unchanged.
REQ-029 When CONV_ADAPTER_RELU_EN is not defined, out_data SHALL equal the captured conv_result value bit-exactly.

Structure
REQ-030 The shared package conv_pkg SHALL hold:
- ROW_BYTES=32, RES_COUNT=30, PIX_W=8, RES_W=18;
- the adapter state enum type;
- the result word typedef.
REQ-031 The drain logic SHALL live in a single sub-module, conv_result_serializer (buffer capture, index counter, valid/ready output stage, optional ReLU), and the top SHALL hold the FSM and the packer.

Verification
REQ-032 Bytes 0x00..0x1F streamed back-to-back -> conv_row[7:0]=0x00 and conv_row[255:248]=0x1F; conv_start pulses once, the cycle after byte 0x1F.
REQ-033 conv_result[i]=i-15 with conv_done pulsed, out_ready=1 -> 30 words -15..14 on consecutive cycles; out_last only on 14.
- With CONV_ADAPTER_RELU_EN defined -> 0 x15, then 0..14.
REQ-034 out_ready toggling 1/0 each cycle during DRAIN -> no word dropped or duplicated; out_data stable while stalled; 60 cycles to drain.
REQ-035 No conv_done for TIMEOUT_CYCLES=8 -> timeout_err pulses once 8 cycles after WAIT entry; in_ready=1 next cycle; no out_valid.
REQ-036 rst_n low after byte 20, then 32 new bytes -> conv_row holds only the new bytes; exactly one conv_start.
REQ-037 in_valid held high during WAIT and DRAIN with conv_done driven in FILL -> no bytes accepted; no spurious result capture.
